hvac_actuator_sequencer: RTL

Downstream stage of the HVAC mode controller. It consumes the controller's heat/cool/system-on outputs and drives the physical heating element, cooling compressor and blower fan. It enforces fan lead/lag purge, minimum element on-time and minimum off-time (short-cycle protection), and guarantees that heating and cooling are never energised together. All timing is counted in ticks of an external timebase strobe.

---
 rtl/hvac_actuator_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/hvac_actuator_sequencer.sv
// hvac_actuator_sequencer
//   Drives the heating element, compressor and blower from the mode
//   controller's heat/cool/on outputs. Adds a fan lead purge before the
//   element, holds the element for a minimum on-time, runs a fan lag purge
//   afterwards and enforces a minimum rest before any new run. Heating and
//   cooling can never be energised together because every changeover
//   passes through LAG and REST. All durations are counted in tick strobes.
//
// Ports
//   clk       clock
//   reset     synchronous, active-high reset (enters REST)
//   tick      single-cycle timebase strobe
//   sys_on    system enabled
//   heat_req  heating requested
//   cool_req  cooling requested
//   estop     emergency stop, level-sensitive
//   heat_en   heating element drive
//   cool_en   compressor drive
//   fan_en    blower drive
//   busy      high in every state except IDLE
//   fault     heat and cool requested together while enabled (registered)
//   state_o   current state: IDLE=0 LEAD=1 RUN_HEAT=2 RUN_COOL=3 LAG=4 REST=5
module hvac_actuator_sequencer #(
  parameter int CNT_W    = 8,
  parameter int FAN_LEAD = 2,
  parameter int MIN_ON   = 8,
  parameter int FAN_LAG  = 4,
  parameter int MIN_OFF  = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       sys_on,
  input  logic       heat_req,
  input  logic       cool_req,
  input  logic       estop,
  output logic       heat_en,
  output logic       cool_en,
  output logic       fan_en,
  output logic       busy,
  output logic       fault,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LEAD     = 3'd1,
    RUN_HEAT = 3'd2,
    RUN_COOL = 3'd3,
    LAG      = 3'd4,
    REST     = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] LEAD_END = CNT_W'(FAN_LEAD);
  localparam logic [CNT_W-1:0] ON_END   = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] LAG_END  = CNT_W'(FAN_LAG);
  localparam logic [CNT_W-1:0] OFF_END  = CNT_W'(MIN_OFF);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] count;
  logic             mode;       // 0 = heat, 1 = cool; latched on IDLE->LEAD
  logic             skip_rest;  // run aborted in LEAD, element never energised
  logic             req_h;
  logic             req_c;
  logic             mode_req;

  // Conflicting requests cancel each other out.
  assign req_h    = sys_on & heat_req & ~cool_req;
  assign req_c    = sys_on & cool_req & ~heat_req;
  assign mode_req = mode ? req_c : req_h;
  assign state_o  = state;

  always_ff @(posedge clk) begin
    if (reset) state <= REST;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (estop) begin
      next_state = REST;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_h || req_c) next_state = LEAD;
        end
        LEAD: begin
          if (!mode_req)              next_state = LAG;
          else if (count == LEAD_END) next_state = mode ? RUN_COOL : RUN_HEAT;
        end
        RUN_HEAT, RUN_COOL: begin
          // Minimum on-time wins over a dropped or changed request.
          if (!mode_req && (count >= ON_END)) next_state = LAG;
        end
        LAG: begin
          if (count == LAG_END) next_state = skip_rest ? IDLE : REST;
        end
        REST: begin
          if (count == OFF_END) next_state = IDLE;
        end
        default: next_state = REST;
      endcase
    end
  end

  // Phase counter: restarts on every state change, frozen at zero during
  // estop so the rest period is measured from estop release.
  always_ff @(posedge clk) begin
    if (reset || estop || (next_state != state)) count <= '0;
    else if (tick && (count != CNT_MAX))         count <= count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode      <= 1'b0;
      skip_rest <= 1'b0;
    end else begin
      if ((state == IDLE) && (next_state == LEAD)) mode <= req_c;
      if ((state == LEAD) && (next_state == LAG))      skip_rest <= 1'b1;
      else if ((state == LAG) && (next_state != LAG))  skip_rest <= 1'b0;
    end
  end

  // Outputs are registered from the next state so they track state exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      heat_en <= 1'b0;
      cool_en <= 1'b0;
      fan_en  <= 1'b0;
      busy    <= 1'b1;
      fault   <= 1'b0;
    end else begin
      heat_en <= (next_state == RUN_HEAT);
      cool_en <= (next_state == RUN_COOL);
      fan_en  <= (next_state == LEAD) || (next_state == RUN_HEAT) ||
                 (next_state == RUN_COOL) || (next_state == LAG);
      busy    <= (next_state != IDLE);
      fault   <= sys_on & heat_req & cool_req;
    end
  end

  a_no_overlap : assert property (@(posedge clk) disable iff (reset)
    !(heat_en && cool_en));
  a_fan_with_load : assert property (@(posedge clk) disable iff (reset)
    !((heat_en || cool_en) && !fan_en));

endmodule
